// File: rtl/xlr8_tone_gen_pkg.sv
// xlr8_tone_gen_pkg: shared widths and per-channel configuration record for the tone generator
package xlr8_tone_gen_pkg;
    localparam int PER_W        = 16;
    localparam int MAX_CH       = 8;
    localparam int CTRL_GEN_BIT = 0;
    typedef struct packed {
        logic [PER_W-1:0] period;
        logic [7:0]       burst;
    } ch_cfg_t;
endpackage

// File: rtl/xlr8_tone_chan.sv
// xlr8_tone_chan: one square-wave channel (tick counter, toggle, burst countdown, done pulse)
// Ports: clk, rst (async, active-high); run = GEN && channel enable; tick = prescaled strobe;
//        commit = new period written; load/load_val = burst count reload; period/burst = config;
//        spk = speaker pin (registered); done = last burst toggle this cycle (combinational).
module xlr8_tone_chan
    import xlr8_tone_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             tick,
    input  logic             commit,
    input  logic             load,
    input  logic [7:0]       load_val,
    input  logic [PER_W-1:0] period,
    input  logic [7:0]       burst,
    output logic             spk,
    output logic             done
);
    logic [PER_W-1:0] cnt;
    logic [7:0]       rem;
    logic             term;
    // a commit in the same cycle as the terminal tick suppresses the toggle
    assign term = run && period != '0 && !commit && tick && cnt == period - 1'b1;
    // rem == 0 means continuous; rem == 1 marks the final toggle of a burst
    assign done = term && rem == 8'd1;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            spk <= 1'b0;
            rem <= '0;
        end else begin
            if (!run || period == '0) begin
                cnt <= '0;
                spk <= 1'b0;
            end else if (commit) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= term ? '0 : cnt + 1'b1;
                if (term) spk <= done ? 1'b0 : !spk;
            end
            // idle channels keep the programmed count armed for the next enable
            rem <= load ? load_val : !run ? burst : (term && rem != '0) ? rem - 1'b1 : rem;
        end
endmodule

// File: rtl/xlr8_tone_gen.sv
// xlr8_tone_gen: multi-channel square-wave tone generator XB on the AVR data-memory bus
// Optional feature: define XLR8_TONE_GEN_BURST_EN for per-channel BURST and sticky STAT registers.
// Ports: clk; rst (async, active-high); clken gates writes and prescaler;
//        dbus_in/ramadr/ramre/ramwe/dm_sel = AVR bus; dbus_out/io_out_en = combinational read data;
//        spk_out[NUM_CH] = speaker pins.
module xlr8_tone_gen
    import xlr8_tone_gen_pkg::*;
#(
    parameter logic [7:0] CTRL_ADDR  = 8'd0,
    parameter logic [7:0] CHEN_ADDR  = 8'd0,
    parameter logic [7:0] CHSEL_ADDR = 8'd0,
    parameter logic [7:0] PERL_ADDR  = 8'd0,
    parameter logic [7:0] PERH_ADDR  = 8'd0,
    parameter logic [7:0] BURST_ADDR = 8'd0,
    parameter logic [7:0] STAT_ADDR  = 8'd0,
    parameter int         NUM_CH     = 2,
    parameter int         PRESCALE   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [7:0]        dbus_in,
    output logic [7:0]        dbus_out,
    output logic              io_out_en,
    input  logic [7:0]        ramadr,
    input  logic              ramre,
    input  logic              ramwe,
    input  logic              dm_sel,
    output logic [NUM_CH-1:0] spk_out
);
    localparam int PS_W = $clog2(PRESCALE);
    logic [7:0]                  ctrl, stage, per_lo, per_hi, opt_d;
    logic [$clog2(MAX_CH)-1:0]   chsel;
    logic [NUM_CH-1:0]           chen, commit, bload, done;
    logic [PS_W-1:0]             ps;
    logic                        wr, gen, tick, opt_e;
    logic                        sel_ctrl, sel_chen, sel_chsel, sel_perl, sel_perh;
    ch_cfg_t                     cfg [NUM_CH];
    assign sel_ctrl  = dm_sel && ramadr == CTRL_ADDR;
    assign sel_chen  = dm_sel && ramadr == CHEN_ADDR;
    assign sel_chsel = dm_sel && ramadr == CHSEL_ADDR;
    assign sel_perl  = dm_sel && ramadr == PERL_ADDR;
    assign sel_perh  = dm_sel && ramadr == PERH_ADDR;
    assign wr   = ramwe && clken;
    assign gen  = ctrl[CTRL_GEN_BIT];
    assign tick = gen && clken && ps == PS_W'(PRESCALE - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ctrl  <= '0;
            chen  <= '0;
            chsel <= '0;
            stage <= '0;
            ps    <= '0;
        end else begin
            if (wr && sel_ctrl) ctrl <= dbus_in;
            if (wr && sel_chsel) chsel <= dbus_in[$clog2(MAX_CH)-1:0];
            if (wr && sel_perl) stage <= dbus_in;
            // a finished burst clears its enable even against a same-cycle write
            chen <= (wr && sel_chen ? dbus_in[NUM_CH-1:0] : chen) & ~done;
            ps   <= (!gen || tick) ? '0 : clken ? ps + 1'b1 : ps;
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) cfg <= '{default: '0};
        else
            for (int k = 0; k < NUM_CH; k++) begin
                if (commit[k]) cfg[k].period <= {dbus_in, stage};
`ifdef XLR8_TONE_GEN_BURST_EN
                if (bload[k]) cfg[k].burst <= dbus_in;
`endif
            end
    always_comb begin
        per_lo = '0;
        per_hi = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (32'(chsel) == k) {per_hi, per_lo} = cfg[k].period;
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // out-of-range CHSEL matches no channel, so those writes fall away
        assign commit[i] = wr && sel_perh && 32'(chsel) == i;
`ifdef XLR8_TONE_GEN_BURST_EN
        assign bload[i] = wr && dm_sel && ramadr == BURST_ADDR && 32'(chsel) == i;
`else
        assign bload[i] = 1'b0;
`endif
        xlr8_tone_chan u_chan (
            .clk      (clk),
            .rst      (rst),
            .run      (gen && chen[i]),
            .tick     (tick),
            .commit   (commit[i]),
            .load     (bload[i]),
            .load_val (dbus_in),
            .period   (cfg[i].period),
            .burst    (cfg[i].burst),
            .spk      (spk_out[i]),
            .done     (done[i])
        );
    end
`ifdef XLR8_TONE_GEN_BURST_EN
    logic [NUM_CH-1:0] stat;
    logic [7:0]        bst;
    logic              sel_burst, sel_stat;
    assign sel_burst = dm_sel && ramadr == BURST_ADDR;
    assign sel_stat  = dm_sel && ramadr == STAT_ADDR;
    // sticky done bits: write-1-to-clear, hardware set wins
    always_ff @(posedge clk or posedge rst)
        if (rst) stat <= '0;
        else stat <= (wr && sel_stat ? stat & ~dbus_in[NUM_CH-1:0] : stat) | done;
    always_comb begin
        bst = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (32'(chsel) == k) bst = cfg[k].burst;
    end
    assign opt_d = (ramre && sel_burst ? bst : '0) | (ramre && sel_stat ? 8'(stat) : '0);
    assign opt_e = ramre && (sel_burst || sel_stat);
`else
    assign opt_d = '0;
    assign opt_e = 1'b0;
`endif
    assign dbus_out = (ramre && sel_ctrl  ? ctrl      : '0)
                    | (ramre && sel_chen  ? 8'(chen)  : '0)
                    | (ramre && sel_chsel ? 8'(chsel) : '0)
                    | (ramre && sel_perl  ? per_lo    : '0)
                    | (ramre && sel_perh  ? per_hi    : '0)
                    | opt_d;
    assign io_out_en = ramre && (sel_ctrl || sel_chen || sel_chsel || sel_perl || sel_perh) || opt_e;
endmodule

// File: tb/tb_xlr8_tone_gen.sv
// tb_xlr8_tone_gen: register vectors plus tone, commit, freeze, burst and reset sequences
module tb_xlr8_tone_gen;
    localparam logic [7:0] A_CTRL = 8'h20, A_CHEN = 8'h21, A_CHSEL = 8'h22, A_PERL = 8'h23;
    localparam logic [7:0] A_PERH = 8'h24, A_BURST = 8'h25, A_STAT = 8'h26;
    localparam int NCH = 2;
    logic clk = 0, rst = 0, clken = 1, ramre = 0, ramwe = 0, dm_sel = 0;
    logic [7:0] dbus_in = 0, ramadr = 0, dbus_out;
    logic io_out_en;
    logic [NCH-1:0] spk_out, prev = '0;
    int checks = 0, errors = 0, cyc = 0;
    int tgl [NCH] = '{default: 0};
    int last [NCH] = '{default: 0};
    typedef struct {logic [7:0] d; logic en; string nm;} rd_t;
    rd_t sb [$];
    typedef struct {logic [7:0] wa, wd, ra, re;} vec_t;
    vec_t tbl [14];

    xlr8_tone_gen #(
        .CTRL_ADDR(A_CTRL), .CHEN_ADDR(A_CHEN), .CHSEL_ADDR(A_CHSEL), .PERL_ADDR(A_PERL),
        .PERH_ADDR(A_PERH), .BURST_ADDR(A_BURST), .STAT_ADDR(A_STAT), .NUM_CH(NCH), .PRESCALE(16)
    ) dut (
        .clk(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in), .dbus_out(dbus_out),
        .io_out_en(io_out_en), .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe),
        .dm_sel(dm_sel), .spk_out(spk_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NCH; i++)
            if (spk_out[i] !== prev[i]) begin
                tgl[i]++;
                last[i] = cyc;
            end
        prev = spk_out;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        step;
        dm_sel = 1; ramadr = a; dbus_in = d; ramwe = 1;
        step;
        dm_sel = 0; ramwe = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] d, input logic en, input string nm);
        rd_t r;
        dm_sel = 1; ramadr = a; ramre = 1;
        sb.push_back('{d, en, nm});
        #1;
        r = sb.pop_front();
        chk(r.nm, dbus_out, r.d);
        chk({r.nm, "_en"}, io_out_en, r.en);
        dm_sel = 0; ramre = 0;
    endtask

    task automatic wait_tgl(input int ch, input int n, input string nm);
        int k = 0;
        while (tgl[ch] < n && k < 5000) begin
            step;
            k++;
        end
        chk(nm, int'(tgl[ch] >= n), 1);
    endtask

    initial begin
        int c0, t, e;
        logic lvl;
        tbl = '{
            '{A_CTRL,  8'hA4, A_CTRL,  8'hA4},
            '{A_CHEN,  8'hFF, A_CHEN,  8'h03},
            '{A_CHSEL, 8'h07, A_CHSEL, 8'h07},
            '{A_CHSEL, 8'h01, A_CHSEL, 8'h01},
            '{A_PERL,  8'h5A, A_PERL,  8'h00},
            '{A_PERH,  8'h12, A_PERH,  8'h12},
            '{A_PERL,  8'h77, A_PERL,  8'h5A},
            '{A_CHSEL, 8'h00, A_PERH,  8'h00},
            '{A_CHSEL, 8'h05, A_PERL,  8'h00},
            '{A_PERH,  8'h99, A_PERH,  8'h00},
            '{A_CHSEL, 8'h01, A_PERH,  8'h12},
            '{A_CHSEL, 8'h00, A_PERL,  8'h00},
            '{A_CHEN,  8'h00, A_CHEN,  8'h00},
            '{A_CTRL,  8'h00, A_CTRL,  8'h00}
        };
        #2 rst = 1;
        repeat (3) step;
        chk("rst_spk", spk_out, 0);
        chk("rst_dbus", dbus_out, 0);
        chk("rst_en", io_out_en, 0);
        rst = 0;
        rd(A_CTRL, 0, 1, "rst_ctrl");
        rd(A_CHEN, 0, 1, "rst_chen");
        rd(A_PERH, 0, 1, "rst_perh");

        for (int i = 0; i < 14; i++) begin
            wr(tbl[i].wa, tbl[i].wd);
            rd(tbl[i].ra, tbl[i].re, 1, $sformatf("vec%0d", i));
        end
        chk("gen_off_spk", spk_out, 0);

        wr(A_CHSEL, 8'h00);
        wr(A_PERL, 8'h03);
        wr(A_PERH, 8'h00);
        wr(A_CHEN, 8'h01);
        t = tgl[0];
        wr(A_CTRL, 8'h01);
        c0 = cyc;
        wait_tgl(0, t + 1, "edge1_seen");
        chk("first_rise", last[0] - c0, 48);
        chk("first_level", spk_out[0], 1);
        e = last[0];
        wait_tgl(0, t + 2, "edge2_seen");
        chk("half1", last[0] - e, 48);
        chk("fall_level", spk_out[0], 0);
        e = last[0];
        wait_tgl(0, t + 3, "edge3_seen");
        chk("half2", last[0] - e, 48);
        chk("ch1_idle", spk_out[1], 0);

        wr(A_PERL, 8'h10);
        rd(A_PERL, 8'h03, 1, "staged_only");
        wr(A_PERH, 8'h00);
        c0 = cyc;
        t = tgl[0];
        rd(A_PERL, 8'h10, 1, "committed");
        wait_tgl(0, t + 1, "commit_edge_seen");
        chk("commit_restart", int'(last[0] - c0 >= 241 && last[0] - c0 <= 256), 1);
        e = last[0];
        wait_tgl(0, t + 2, "commit_edge2_seen");
        chk("half_p16", last[0] - e, 256);

        e = last[0];
        t = tgl[0];
        repeat (10) step;
        clken = 0;
        lvl = spk_out[0];
        wr(A_CHEN, 8'h00);
        wr(A_CTRL, 8'h00);
        rd(A_CHEN, 8'h01, 1, "frozen_chen");
        rd(A_CTRL, 8'h01, 1, "frozen_ctrl");
        repeat (96) step;
        chk("frozen_tgl", tgl[0], t);
        chk("frozen_lvl", spk_out[0], lvl);
        clken = 1;
        wait_tgl(0, t + 1, "thaw_edge_seen");
        chk("thaw_half", last[0] - e, 356);

`ifdef XLR8_TONE_GEN_BURST_EN
        wr(A_CHSEL, 8'h01);
        wr(A_PERL, 8'h02);
        wr(A_PERH, 8'h00);
        wr(A_BURST, 8'h04);
        rd(A_BURST, 8'h04, 1, "burst_rd");
        t = tgl[1];
        wr(A_CHEN, 8'h03);
        wait_tgl(1, t + 4, "burst_seen");
        repeat (200) step;
        chk("burst_toggles", tgl[1] - t, 4);
        chk("burst_low", spk_out[1], 0);
        rd(A_CHEN, 8'h01, 1, "burst_chen");
        rd(A_STAT, 8'h02, 1, "stat_set");
        wr(A_STAT, 8'h02);
        rd(A_STAT, 8'h00, 1, "stat_clr");
`else
        rd(A_BURST, 8'h00, 0, "burst_undecoded");
        rd(A_STAT, 8'h00, 0, "stat_undecoded");
`endif

        rst = 1;
        #1;
        chk("midrst_spk", spk_out, 0);
        rd(A_CTRL, 0, 1, "midrst_ctrl");
        rd(A_CHEN, 0, 1, "midrst_chen");
        rd(A_CHSEL, 0, 1, "midrst_chsel");
        rd(A_PERL, 0, 1, "midrst_perl");
        rd(A_PERH, 0, 1, "midrst_perh");
        ramre = 1; ramadr = A_CTRL;
        #1;
        chk("no_sel_en", io_out_en, 0);
        ramre = 0;
        step;
        rst = 0;
        repeat (40) step;
        chk("post_rst_spk", spk_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xlr8_tone_gen.md
# xlr8_tone_gen

Multi-channel square-wave tone generator XB for the XLR8 AVR core; parametrised successor to the two-speaker on/off block. Each of NUM_CH channels divides a shared prescaled tick by a programmable 16-bit half-period and drives one speaker pin. All channel state is programmed through the standard AVR data-memory register interface: control, channel select, period low/high, channel enable, and an optional burst/status pair.

## Interface
- CTRL_ADDR, 0: global control register address (RW)
- CHEN_ADDR, 0: per-channel enable register address (RW)
- CHSEL_ADDR, 0: channel select register address (RW)
- PERL_ADDR, 0: period low byte address (RW, staged)
- PERH_ADDR, 0: period high byte address (RW, commits)
- BURST_ADDR, 0: burst count address (XLR8_TONE_GEN_BURST_EN only)
- STAT_ADDR, 0: done status address (XLR8_TONE_GEN_BURST_EN only)
- NUM_CH, 2: channel count, 1..8
- PRESCALE, 16: clk cycles per tick, >=2
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clken  in  1  clock enable; gates register writes and the prescaler
- dbus_in  in  8  AVR write data
- dbus_out  out  8  AVR read data
- io_out_en  out  1  read-data valid for this XB
- ramadr  in  8  RAM address
- ramre  in  1  RAM read enable
- ramwe  in  1  RAM write enable
- dm_sel  in  1  DM select
- spk_out  out  NUM_CH  speaker pins, one per channel

## Operation
- Register select: sel_X = dm_sel && ramadr==X_ADDR; write = sel && ramwe && clken; io_out_en = OR of (sel && ramre) over decoded registers.
- CTRL[0] global enable (GEN); CTRL[7:1] stored, no effect.
- CHEN[NUM_CH-1:0]: per-channel enable; upper bits read 0.
- CHSEL[2:0]: target for PERL/PERH/BURST; CHSEL>=NUM_CH: those writes ignored, reads return 0.
- PERL write: stores into staging byte only. PERH write: commits {dbus_in, staging} to selected channel's period atomically. Reads return committed period bytes.
- Prescaler: counts 0..PRESCALE-1 while GEN && clken; tick = one-cycle pulse at PRESCALE-1. GEN=0 holds prescaler at 0.
- Channel (enabled, period P>0): counter increments per tick; on tick with counter==P-1 output toggles, counter -> 0. Half-period = P*PRESCALE clk cycles.
- P==0, channel disabled, or GEN=0: output low, counter 0.
- Enable rising edge: counter 0, output low; first toggle after P ticks.
- Commit on a channel: counter -> 0, output level kept. Commit and terminal tick same cycle: commit wins, no toggle.
- Reset mid-tone: all state cleared immediately; outputs low.

## Timing
- Reset values: all registers 0, spk_out 0, dbus_out 0, io_out_en 0.
- Writes visible in registers the cycle after the write strobe.
- Reads combinational: dbus_out/io_out_en valid same cycle as ramre.
- spk_out registered: changes the cycle after the terminal tick.
- CHEN/GEN changes affect outputs one cycle after the write.

## Configuration
- XLR8_TONE_GEN_BURST_EN defined: per-channel 8-bit BURST register (0 = continuous). Nonzero B: after B toggles channel's CHEN bit clears, output low, STAT[ch] done bit sets. Writing BURST or rising enable reloads remaining count. STAT bits sticky, write-1-to-clear; hardware set beats same-cycle clear.
- Undefined: BURST_ADDR/STAT_ADDR not decoded (no io_out_en, dbus_out 0 contribution); channels always continuous.

## Structure
- Package xlr8_tone_gen_pkg: PER_W=16, MAX_CH=8, CTRL_GEN_BIT, typedef ch_cfg_t {period[15:0], burst[7:0]}.
- Sub-module xlr8_tone_chan: per-channel counter, toggle, burst countdown, done pulse; instantiated NUM_CH times via generate.

## Test plan
- Reset asserted mid-tone -> spk_out 0, all register reads 0, io_out_en 0 same cycle as read.
- GEN=1, CHSEL=0, PERL=0x03, PERH=0x00, CHEN=0x01, PRESCALE=16 -> spk_out[0] toggles every 48 clk; first rise 48 clk after enable.
- PERL=0x10 alone -> period readback unchanged; PERH=0x00 -> period 0x0010, counter restarts.
- CHSEL=5 with NUM_CH=2, PERH write -> no channel changes, period read returns 0.
- Burst build: BURST=4, CHEN=0x02, P=2 -> exactly 4 toggles on spk_out[1], CHEN[1]=0, STAT=0x02; write STAT=0x02 -> STAT=0.
- clken low for 100 cycles while running -> prescaler and outputs frozen, AVR writes ignored.
